// File: rtl/rr_priority_encoder_pkg.sv
// Shared constants and width helper for the round-robin priority encoder.
package rr_priority_encoder_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Index width with a floor of one bit so N=1-style corner widths never collapse to zero.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_encoder_prio_pick.sv
// Combinational lowest-set-bit picker: binary index, one-hot and any-set flag.
module prio_pick
    import rr_priority_encoder_pkg::*;
#(
    parameter int  N = 8,
    localparam int W = idx_width(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot,
    output logic         any
);

    // Two's-complement trick isolates the lowest set bit; zero input gives zero.
    assign onehot = req & (~req + N'(1));
    assign any    = |req;

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = W'(i);
        end
    end

endmodule

// File: rtl/rr_priority_encoder.sv
// N-to-log2(N) encoder, fixed or round-robin priority, with a one-entry registered output.
module rr_priority_encoder
    import rr_priority_encoder_pkg::*;
#(
    parameter int  N    = 8,
    parameter int  MODE = MODE_RR,
    localparam int W    = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         out_zero
);

    logic [W-1:0] ptr;
    logic [N-1:0] mask;
    logic [N-1:0] req_masked;
    logic [W-1:0] m_idx, u_idx, sel_idx;
    logic [N-1:0] m_oh, u_oh, sel_oh;
    logic         m_any, u_any;
    logic         accept;

    assign in_ready = en & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    // Bits at or above the pointer; ptr stays 0 in fixed mode so the mask is all ones.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i >= int'(ptr));
        end
    end

    assign req_masked = req & mask;

    prio_pick #(.N(N)) u_pick_masked (
        .req    (req_masked),
        .idx    (m_idx),
        .onehot (m_oh),
        .any    (m_any)
    );

    prio_pick #(.N(N)) u_pick_full (
        .req    (req),
        .idx    (u_idx),
        .onehot (u_oh),
        .any    (u_any)
    );

    // No set bit at/above ptr means wrap to the lowest set bit overall.
    assign sel_idx = m_any ? m_idx : u_idx;
    assign sel_oh  = m_any ? m_oh  : u_oh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if ((MODE == MODE_RR) && accept && u_any) begin
            ptr <= (sel_idx == W'(N - 1)) ? '0 : sel_idx + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_onehot <= '0;
            out_zero   <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_idx    <= sel_idx;
            out_onehot <= sel_oh;
            out_zero   <= ~u_any;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule
